mop_instr_sequencer: RTL
========================

# mop_instr_sequencer

- Eight-entry instruction buffer plus execution sequencer for the MOP redirect path.
- Upstream: the instruction loader, which writes 17-bit words through the `ext_wr` / `ext_addr` / `ext_data_in` port.
- Downstream: the redirect stage. Executing the buffer issues `source`/`target` redirect commands to it over a valid/ready handshake; WAIT and HALT instructions control pacing and termination.

## Interface

Parameters:
- `ID_W`, default 4: width of initiator IDs (`ariane_soc::LOG_N_INIT`); legal range 1..7.
- `DEPTH`, default 8: number of buffer entries; fixed at 8.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `ext_wr_i` in 1: buffer write strobe.
- `ext_addr_i` in 3: buffer write address.
- `ext_data_in_i` in 17: instruction word to write.
- `start_i` in 1: begin execution at entry 0.
- `abort_i` in 1: terminate execution immediately.
- `ready_i` in 1: redirect stage accepts the command.
- `valid_o` out 1: redirect command valid.
- `source_o` out ID_W: requesting initiator ID.
- `target_o` out ID_W: receiving initiator ID.
- `busy_o` out 1: sequencer not IDLE.
- `done_o` out 1: one-cycle pulse on normal completion.
- `wr_err_o` out 1: one-cycle pulse; a write was rejected.
- `pc_o` out 3: current instruction index.

## Operation

Instruction encoding:
- Opcode is `[16:15]`.
- `00` NOP.
- `01` REDIRECT: source = `[8 +: ID_W]`, target = `[0 +: ID_W]`.
- `10` WAIT: count = `[7:0]`.
- `11` HALT.
- Bits outside the used fields are ignored.

Buffer:
- 8 x 17-bit storage plus an 8-bit `loaded` mask.
- Reset clears the mask; data contents are don't-care.
- Writes are accepted only in IDLE: the entry is written and its `loaded` bit is set. Overwriting an entry is allowed.
- A write in any other state is dropped and `wr_err_o` pulses the next cycle.

State machine:
- IDLE:
  - `start_i` -> FETCH with pc = 0. Otherwise stay.
- FETCH: decode `mem[pc]` in one cycle.
  - Unloaded entry or HALT -> DONE.
  - NOP -> advance.
  - REDIRECT -> latch source/target, go to ISSUE.
  - WAIT with N = 0 -> advance.
  - WAIT with N > 0 -> load counter with N, go to WAIT.
- ISSUE:
  - `valid_o` = 1; `source_o`/`target_o` stay stable while stalled.
  - Leave only on `valid_o && ready_i` -> advance.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 1 -> advance (N cycles in WAIT in total).
- Advance:
  - pc = 7 -> DONE.
  - Otherwise pc + 1 -> FETCH.
  - No wrap-around.
- DONE:
  - `done_o` = 1 for exactly one cycle, then -> IDLE with pc = 0.

Control rules:
- `abort_i` from any non-IDLE state:
  - Next state is IDLE; pc = 0; `valid_o` = 0 next cycle.
  - No `done_o` pulse.
  - An in-flight handshake in the same cycle (`valid_o && ready_i && abort_i`) counts as accepted, but no further instruction runs.
- `abort_i` has priority over `start_i`.
- `start_i` outside IDLE is ignored.
- Write and `start_i` in the same IDLE cycle: the write commits first, so the first FETCH sees the new word.

## Timing

- All outputs come from registers or decode directly from the state register. No combinational path from `ready_i` to `valid_o`.
- Reset values: `valid_o` = 0, `source_o` = 0, `target_o` = 0, `busy_o` = 0, `done_o` = 0, `wr_err_o` = 0, `pc_o` = 0, state = IDLE, `loaded` = 0. Reset overrides every other input, including mid-operation.
- Latencies, with `start_i` at cycle t:
  - FETCH at t+1.
  - A REDIRECT in entry 0 raises `valid_o` at t+2.
- Per-instruction cost:
  - NOP: 1 cycle.
  - REDIRECT: 1 + (cycles until `ready_i`).
  - WAIT N: 1 + N cycles.
  - HALT: 1 cycle, then 1 DONE cycle.
- `busy_o` = 1 in FETCH, ISSUE, WAIT and DONE.
- `wr_err_o` pulses one cycle after the rejected write.

## Test plan

- **Basic program.** Load entry0 = 0x08205, entry1 = 0x10003, entry2 = 0x18000; hold `ready_i` = 1; `start_i` at t.
  - `valid_o` = 1 at t+2 only, with `source_o` = 2, `target_o` = 5.
  - WAIT state t+4..t+6.
  - `done_o` pulse at t+8; `busy_o` low at t+9.
- **Backpressure.** Same program with `ready_i` = 0 for t+2..t+5, then 1.
  - `valid_o` held high t+2..t+6 with stable IDs.
  - `done_o` at t+12.
- **Full run, no halt.** Load all 8 entries with NOP (0x00000); start at t.
  - FETCH t+1..t+8 with `pc_o` 0..7.
  - `done_o` at t+9; pc returns to 0 (no wrap).
- **Unloaded entry.** After reset, load only entry0 = 0x08103; start.
  - One redirect with source 1, target 3.
  - Entry1 is unloaded, so the sequencer terminates like HALT and `done_o` pulses.
- **Write while busy.** During WAIT of a 0x100FF instruction, write entry3.
  - `wr_err_o` pulses the next cycle.
  - Entry3 is unchanged; a later read-back via execution confirms it.
- **Abort and reset.** During ISSUE with `ready_i` = 0, assert `abort_i`.
  - IDLE next cycle; `valid_o` = 0; no `done_o`.
  - Assert `rst_i` mid-WAIT: all outputs take their reset values next cycle and `loaded` is cleared.

Source files
------------

// File: rtl/mop_instr_sequencer.sv
// Eight-entry instruction buffer and execution sequencer for the MOP redirect path.
// Programs are loaded while idle, then run from entry 0, issuing source/target redirects.
module mop_instr_sequencer #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ext_wr_i,
  input  logic [2:0]      ext_addr_i,
  input  logic [16:0]     ext_data_in_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [ID_W-1:0] source_o,
  output logic [ID_W-1:0] target_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            wr_err_o,
  output logic [2:0]      pc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_REDIR = 2'b01;
  localparam logic [1:0] OP_WAIT  = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  state_e          state_q, state_d;
  logic [2:0]      pc_q, pc_d;
  logic [ID_W-1:0] src_q, src_d;
  logic [ID_W-1:0] tgt_q, tgt_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [DEPTH-1:0] loaded_q, loaded_d;
  logic            wr_err_q, wr_err_d;
  logic [16:0]     mem_q [DEPTH];

  logic            mem_we;
  logic            advance;
  logic [16:0]     instr;
  logic [1:0]      opcode;
  logic            unused_instr;

  assign instr        = mem_q[pc_q];
  assign opcode       = instr[16:15];
  assign unused_instr = ^instr;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    src_d    = src_q;
    tgt_d    = tgt_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    mem_we   = 1'b0;
    advance  = 1'b0;
    wr_err_d = ext_wr_i && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        // The write commits on the same edge as start, so FETCH sees the new word.
        if (ext_wr_i) begin
          mem_we               = 1'b1;
          loaded_d[ext_addr_i] = 1'b1;
        end
        if (start_i && !abort_i) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        if (!loaded_q[pc_q] || opcode == OP_HALT) begin
          state_d = S_DONE;
        end else begin
          case (opcode)
            OP_NOP:   advance = 1'b1;
            OP_REDIR: begin
              src_d   = instr[8 +: ID_W];
              tgt_d   = instr[0 +: ID_W];
              state_d = S_ISSUE;
            end
            OP_WAIT: begin
              if (instr[7:0] == 8'd0) begin
                advance = 1'b1;
              end else begin
                cnt_d   = instr[7:0];
                state_d = S_WAIT;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_ISSUE: begin
        if (ready_i) advance = 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == 8'd1) advance = 1'b1;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (pc_q == 3'd7) begin
        state_d = S_DONE;
      end else begin
        pc_d    = pc_q + 3'd1;
        state_d = S_FETCH;
      end
    end

    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pc_d    = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      src_q    <= '0;
      tgt_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      src_q    <= src_d;
      tgt_q    <= tgt_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Buffer contents need no reset; the loaded mask decides what is valid.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[ext_addr_i] <= ext_data_in_i;
  end

  assign valid_o  = (state_q == S_ISSUE);
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign source_o = src_q;
  assign target_o = tgt_q;
  assign wr_err_o = wr_err_q;
  assign pc_o     = pc_q;

endmodule
